// File: rtl/regdst_pipe.sv
// regdst_pipe: write-destination select (rd / rt / link) tracked through DEPTH stages with
// stall, flush and load-use hazard detection. Define REGDST_FWD_EN to add EX forwarding selects.
module regdst_pipe #(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LINK_REG = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AW-1:0]         TipoR,
    input  logic [AW-1:0]         TipoI,
    input  logic [1:0]            regdst,
    input  logic                  regwrite,
    input  logic                  memread,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [AW-1:0]         rs_q,
    input  logic [AW-1:0]         rt_q,
`ifdef REGDST_FWD_EN
    input  logic [AW-1:0]         ex_rs,
    input  logic [AW-1:0]         ex_rt,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
`endif
    output logic [AW-1:0]         smux2,
    output logic [DEPTH*AW-1:0]   dest_q,
    output logic [DEPTH-1:0]      wen_q,
    output logic                  hazard
);

    localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};
    localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);

    typedef struct packed {
        logic [AW-1:0] dest;
        logic          wen;
        logic          ld;
    } stage_t;

    localparam stage_t BUBBLE = '{dest: {AW{1'b0}}, wen: 1'b0, ld: 1'b0};

    generate
        if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
            $error("regdst_pipe: DEPTH must be in 2..8");
        end
`ifdef REGDST_FWD_EN
        if (DEPTH < 3) begin : g_bad_fwd_depth
            $error("regdst_pipe: forwarding needs DEPTH >= 3");
        end
`endif
    endgenerate

    function automatic logic [AW-1:0] select_dest(input logic [1:0]    code,
                                                  input logic [AW-1:0] rd,
                                                  input logic [AW-1:0] rt);
        logic [AW-1:0] sel;
        case (code)
            2'b00:   sel = rt;
            2'b01:   sel = rd;
            2'b10:   sel = LINK_ADDR;
            default: sel = ZERO_ADDR;
        endcase
        return sel;
    endfunction

    stage_t        stage_r     [DEPTH];
    stage_t        stage_nxt_s [DEPTH];
    stage_t        entry_s;
    logic [AW-1:0] smux2_s;
    logic          unused_ld_s;

    // Destination select and the entry word presented to stage 0.
    always_comb begin
        smux2_s      = select_dest(regdst, TipoR, TipoI);
        entry_s.dest = smux2_s;
        entry_s.wen  = regwrite & in_valid & (smux2_s != ZERO_ADDR);
        entry_s.ld   = memread & in_valid;
    end

    // Next-state: flush squashes stage 0 and what is leaving it; later stages always shift.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_nxt_s[k] = BUBBLE;
        end
        for (int k = 1; k < DEPTH; k++) begin
            stage_nxt_s[k] = stage_r[k-1];
        end
        if (flush) begin
            stage_nxt_s[0] = BUBBLE;
            stage_nxt_s[1] = BUBBLE;
        end else if (stall) begin
            stage_nxt_s[0] = BUBBLE;
        end else begin
            stage_nxt_s[0] = entry_s;
        end
    end

    // Stage registers; reset returns every stage to a bubble immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= BUBBLE;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= stage_nxt_s[k];
            end
        end
    end

    // Flatten stage registers onto the output buses.
    always_comb begin
        dest_q      = {(DEPTH*AW){1'b0}};
        wen_q       = {DEPTH{1'b0}};
        unused_ld_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            dest_q[k*AW +: AW] = stage_r[k].dest;
            wen_q[k]           = stage_r[k].wen;
            unused_ld_s        = unused_ld_s ^ stage_r[k].ld;
        end
    end

    // Load in EX whose destination feeds the decode instruction's sources.
    always_comb begin
        hazard = stage_r[0].ld & stage_r[0].wen & in_valid &
                 ((stage_r[0].dest == rs_q) | (stage_r[0].dest == rt_q));
    end

    assign smux2 = smux2_s;

`ifdef REGDST_FWD_EN
    function automatic logic [1:0] fwd_select(input logic [AW-1:0] src,
                                              input stage_t        s1,
                                              input stage_t        s2);
        logic [1:0] sel;
        if (src == ZERO_ADDR) begin
            sel = 2'b00;
        end else if (s1.wen && (s1.dest == src)) begin
            sel = 2'b01;
        end else if (s2.wen && (s2.dest == src)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // EX operand forwarding; the younger stage 1 result takes precedence.
    always_comb begin
        fwd_a = fwd_select(ex_rs, stage_r[1], stage_r[2]);
        fwd_b = fwd_select(ex_rt, stage_r[1], stage_r[2]);
    end
`endif

endmodule

// File: tb/tb_regdst_pipe.sv
// Self-checking bench for regdst_pipe: vector table, directed corner sequences and
// randomized stimulus against a history-queue model of the pipeline.
module tb_regdst_pipe;
    localparam int AW    = 5;
    localparam int DEPTH = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AW-1:0]     TipoR, TipoI, rs_q, rt_q;
    logic [1:0]        regdst;
    logic              regwrite, memread, in_valid, stall, flush;
    logic [AW-1:0]     smux2;
    logic [DEPTH*AW-1:0] dest_q;
    logic [DEPTH-1:0]  wen_q;
    logic              hazard;
`ifdef REGDST_FWD_EN
    logic [AW-1:0]     ex_rs, ex_rt;
    logic [1:0]        fwd_a, fwd_b;
`endif

    regdst_pipe #(.AW(AW), .DEPTH(DEPTH), .LINK_REG(31)) dut (
        .clk(clk), .rst_n(rst_n), .TipoR(TipoR), .TipoI(TipoI), .regdst(regdst),
        .regwrite(regwrite), .memread(memread), .in_valid(in_valid),
        .stall(stall), .flush(flush), .rs_q(rs_q), .rt_q(rt_q),
`ifdef REGDST_FWD_EN
        .ex_rs(ex_rs), .ex_rt(ex_rt), .fwd_a(fwd_a), .fwd_b(fwd_b),
`endif
        .smux2(smux2), .dest_q(dest_q), .wen_q(wen_q), .hazard(hazard)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] dest;
        logic       wen;
        logic       ld;
    } ent_t;

    typedef struct {
        logic [1:0] code;
        logic [4:0] rd;
        logic [4:0] rt;
        logic [4:0] exp;
    } vec_t;

    ent_t hist[$];   // newest entry last; stage k is k entries back
    int   errors = 0;
    int   checks = 0;

    function automatic logic [4:0] ref_dest(input logic [1:0] code, input logic [4:0] rd,
                                            input logic [4:0] rt);
        if (code == 2'd0) return rt;
        else if (code == 2'd1) return rd;
        else if (code == 2'd2) return 5'd31;
        else return 5'd0;
    endfunction

    function automatic ent_t model_stage(input int k);
        ent_t b;
        b = '0;
        if (hist.size() > k) b = hist[hist.size()-1-k];
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        ent_t e;
        e.dest = ref_dest(regdst, TipoR, TipoI);
        e.wen  = regwrite && in_valid && (e.dest != 5'd0);
        e.ld   = memread && in_valid;
        if (flush) begin
            if (hist.size() > 0) hist[hist.size()-1] = '0;
            hist.push_back('0);
        end else if (stall) begin
            hist.push_back('0);
        end else begin
            hist.push_back(e);
        end
        if (hist.size() > 16) void'(hist.pop_front());
    endtask

    task automatic check_all(input string tag);
        ent_t s;
        logic hz;
        for (int k = 0; k < DEPTH; k++) begin
            s = model_stage(k);
            chk({tag, "_dest"}, 32'(dest_q[k*AW +: AW]), 32'(s.dest));
            chk({tag, "_wen"}, 32'(wen_q[k]), 32'(s.wen));
        end
        s  = model_stage(0);
        hz = s.ld && s.wen && in_valid && ((s.dest == rs_q) || (s.dest == rt_q));
        chk({tag, "_hazard"}, 32'(hazard), 32'(hz));
        chk({tag, "_smux2"}, 32'(smux2), 32'(ref_dest(regdst, TipoR, TipoI)));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic issue(input logic [4:0] rt, input logic ld);
        regdst = 2'd0; TipoI = rt; regwrite = 1'b1; memread = ld; in_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[6];
        vt[0] = '{2'd0, 5'd12, 5'd7, 5'd7};
        vt[1] = '{2'd1, 5'd12, 5'd7, 5'd12};
        vt[2] = '{2'd2, 5'd12, 5'd7, 5'd31};
        vt[3] = '{2'd3, 5'd12, 5'd7, 5'd0};
        vt[4] = '{2'd0, 5'd3, 5'd0, 5'd0};
        vt[5] = '{2'd1, 5'd0, 5'd9, 5'd0};

        rst_n = 1'b0; TipoR = '0; TipoI = '0; regdst = 2'd0; regwrite = 1'b0;
        memread = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; rs_q = '0; rt_q = '0;
`ifdef REGDST_FWD_EN
        ex_rs = '0; ex_rt = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("reset_dest", 32'(dest_q), 32'd0);
        chk("reset_wen", 32'(wen_q), 32'd0);
        chk("reset_hazard", 32'(hazard), 32'd0);

        // smux2 is combinational and follows its inputs even while in reset
        for (int i = 0; i < 6; i++) begin
            regdst = vt[i].code; TipoR = vt[i].rd; TipoI = vt[i].rt;
            #1;
            chk($sformatf("smux2_vec%0d", i), 32'(smux2), 32'(vt[i].exp));
        end

        // write to register 0 never asserts wen
        rst_n = 1'b1;
        issue(5'd0, 1'b0);
        tick("r0"); tick("r0"); tick("r0");
        chk("r0_wen2", 32'(wen_q[2]), 32'd0);
        chk("r0_dest2", 32'(dest_q[14:10]), 32'd0);

        // load-use hazard, then cleared by a stall bubble
        issue(5'd9, 1'b1);
        tick("ld");
        regdst = 2'd1; TipoR = 5'd2; memread = 1'b0; rs_q = 5'd9; rt_q = 5'd1;
        #1;
        chk("lu_hazard", 32'(hazard), 32'd1);
        stall = 1'b1;
        tick("stall");
        chk("stall_hazard", 32'(hazard), 32'd0);
        chk("stall_wen0", 32'(wen_q[0]), 32'd0);
        chk("stall_dest0", 32'(dest_q[4:0]), 32'd0);
        stall = 1'b0; rs_q = '0; rt_q = '0;

        // C(4), A(5), then B(6) with flush: A squashed, C keeps shifting
        issue(5'd4, 1'b0); tick("flC");
        issue(5'd5, 1'b0); tick("flA");
        issue(5'd6, 1'b0); flush = 1'b1; stall = 1'b1; tick("flB");
        chk("flush_wen10", 32'(wen_q[1:0]), 32'd0);
        chk("flush_wen2", 32'(wen_q[2]), 32'd1);
        chk("flush_dest2", 32'(dest_q[14:10]), 32'd4);
        flush = 1'b0; stall = 1'b0;

        // asynchronous reset mid-stream with every stage valid
        issue(5'd8, 1'b0); tick("pre");
        issue(5'd9, 1'b0); tick("pre");
        issue(5'd10, 1'b0); tick("pre");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wen", 32'(wen_q), 32'd0);
        chk("arst_dest", 32'(dest_q), 32'd0);
        hist.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(5'd3, 1'b0); tick("rel");
        issue(5'd11, 1'b0); tick("rel"); tick("rel");
        chk("rel_dest2", 32'(dest_q[14:10]), 32'd3);
        chk("rel_wen2", 32'(wen_q[2]), 32'd1);

        for (int n = 0; n < 400; n++) begin
            regdst   = 2'($urandom_range(0, 3));
            TipoR    = 5'($urandom_range(0, 7));
            TipoI    = 5'($urandom_range(0, 7));
            rs_q     = 5'($urandom_range(0, 7));
            rt_q     = 5'($urandom_range(0, 7));
            regwrite = ($urandom % 4) != 0;
            memread  = ($urandom % 3) == 0;
            in_valid = ($urandom % 8) != 0;
            stall    = ($urandom % 6) == 0;
            flush    = ($urandom % 9) == 0;
            tick("rnd");
        end

`ifdef REGDST_FWD_EN
        stall = 1'b0; flush = 1'b0;
        issue(5'd4, 1'b0); tick("fw");
        issue(5'd4, 1'b0); tick("fw");
        issue(5'd1, 1'b0); tick("fw");
        ex_rs = 5'd4; ex_rt = 5'd0;
        #1;
        chk("fwd_a", 32'(fwd_a), 32'd1);
        chk("fwd_b", 32'(fwd_b), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
